// File: rtl/polytris_pkg.sv
// Shared POLYTRIS constants and types for the playfield store and the drawing stage.
package polytris_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;

  localparam int BOARD_X0 = 240;
  localparam int BOARD_Y0 = 80;
  localparam int CELL_PX  = 16;

  typedef enum logic [1:0] {
    CELL_EMPTY,
    CELL_A,
    CELL_B,
    CELL_C
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } ps_state_t;

  // A row is full when every 2-bit cell code is non-zero.
  function automatic logic row_full(input logic [2*COLS-1:0] row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      full = full & (|row[2*c +: 2]);
    end
    return full;
  endfunction

endpackage

// File: rtl/playfield_store.sv
// POLYTRIS playfield: piece lock writes, sequential line-clear scan and
// registered per-pixel cell lookup for the drawing stage.
module playfield_store
  import polytris_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  rd_col,
  input  logic [4:0]  rd_row,
  output logic [1:0]  rd_cell,
  input  logic        lock_valid,
  output logic        lock_ready,
  input  logic [15:0] lock_x,
  input  logic [19:0] lock_y,
  input  logic [1:0]  lock_type,
  input  logic        board_clear,
  output logic        lines_done,
  output logic [2:0]  lines_cleared
);

  ps_state_t         r_state;
  ps_state_t         w_next_state;
  logic [2*COLS-1:0] r_board [ROWS];
  logic [4:0]        r_row;
  logic [2:0]        r_count;
  logic [2:0]        r_lines_cleared;
  cell_t             r_rd_cell;

  logic [3:0] w_lx [4];
  logic [4:0] w_ly [4];
  logic       w_accept;
  logic       w_row_full;
  logic       w_rd_in_range;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_lx[i] = lock_x[4*i +: 4];
      w_ly[i] = lock_y[5*i +: 5];
    end
  end

  assign lock_ready    = (r_state == IDLE) && !board_clear;
  assign w_accept      = lock_valid && lock_ready;
  assign w_row_full    = row_full(r_board[r_row]);
  assign w_rd_in_range = (rd_col < 4'(COLS)) && (rd_row < 5'(ROWS));
  assign lines_done    = (r_state == DONE);
  assign lines_cleared = r_lines_cleared;
  assign rd_cell       = r_rd_cell;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SCAN;
      SCAN:    if (!w_row_full && (r_row == 5'd0)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (board_clear) w_next_state = IDLE;
  end

  // A full row is collapsed in place and rechecked, since a new row has moved into it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
      r_row           <= '0;
      r_count         <= '0;
      r_lines_cleared <= '0;
    end else if (board_clear) begin
      for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < 4; i++) begin
              if ((w_lx[i] < 4'(COLS)) && (w_ly[i] < 5'(ROWS)))
                r_board[w_ly[i]][{w_lx[i], 1'b0} +: 2] <= lock_type;
            end
            r_row   <= 5'(ROWS - 1);
            r_count <= '0;
          end
        end
        SCAN: begin
          if (w_row_full) begin
            r_board[0] <= '0;
            for (int r = 1; r < ROWS; r++) begin
              if (5'(r) <= r_row) r_board[r] <= r_board[r-1];
            end
            r_count <= r_count + 3'd1;
          end else if (r_row != 5'd0) begin
            r_row <= r_row - 5'd1;
          end else begin
            r_lines_cleared <= r_count;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)           r_rd_cell <= CELL_EMPTY;
    else if (w_rd_in_range) r_rd_cell <= cell_t'(r_board[rd_row][{rd_col, 1'b0} +: 2]);
    else                    r_rd_cell <= CELL_EMPTY;
  end

endmodule

// File: tb/tb_playfield_store.sv
// Bench for playfield_store: table of lock vectors against a behavioural board
// model, plus hand-written abort and ignored-lock sequences.
module tb_playfield_store;
  import polytris_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  rd_col;
  logic [4:0]  rd_row;
  logic [1:0]  rd_cell;
  logic        lock_valid;
  logic        lock_ready;
  logic [15:0] lock_x;
  logic [19:0] lock_y;
  logic [1:0]  lock_type;
  logic        board_clear;
  logic        lines_done;
  logic [2:0]  lines_cleared;

  playfield_store dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .lock_type(lock_type),
    .board_clear(board_clear),
    .lines_done(lines_done), .lines_cleared(lines_cleared)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] x;
    logic [19:0] y;
    logic [1:0]  t;
    bit          clr;
    int          expK;
    bit          chk;
  } lockVec_t;

  int       total = 0;
  int       bad = 0;
  int       mb [ROWS][COLS];
  int       sbq [$];
  lockVec_t vecs [$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic modelWipe();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
  endtask

  task automatic modelLock(input logic [15:0] x, input logic [19:0] y, input int t);
    for (int i = 0; i < 4; i++) begin
      int xi, yi;
      xi = int'(x[4*i +: 4]);
      yi = int'(y[5*i +: 5]);
      if (xi < COLS && yi < ROWS) mb[yi][xi] = t;
    end
  endtask

  // Repeatedly remove the lowest full row until no full rows remain.
  task automatic modelScan(output int k);
    bit found;
    k = 0;
    do begin
      found = 1'b0;
      for (int r = ROWS - 1; r >= 0 && !found; r--) begin
        bit full = 1'b1;
        for (int c = 0; c < COLS; c++) if (mb[r][c] == 0) full = 1'b0;
        if (full) begin
          found = 1'b1;
          for (int rr = r; rr > 0; rr--)
            for (int c = 0; c < COLS; c++) mb[rr][c] = mb[rr-1][c];
          for (int c = 0; c < COLS; c++) mb[0][c] = 0;
          k++;
        end
      end
    end while (found);
  endtask

  task automatic readCheck(input int c, input int r, input int exp, input string name);
    int e;
    sbq.push_back(exp);
    rd_col = 4'(c);
    rd_row = 5'(r);
    tick();
    e = sbq.pop_front();
    checkOutput(name, 32'(rd_cell), 32'(e));
  endtask

  task automatic checkBoard(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        readCheck(c, r, mb[r][c], $sformatf("%s cell(%0d,%0d)", tag, c, r));
  endtask

  task automatic applyClear();
    board_clear = 1'b1;
    #1;
    checkOutput("ready low during clear", 32'(lock_ready), 32'd0);
    tick();
    board_clear = 1'b0;
    #1;
    checkOutput("ready after clear", 32'(lock_ready), 32'd1);
    modelWipe();
  endtask

  task automatic acceptLock(input logic [15:0] x, input logic [19:0] y, input logic [1:0] t);
    int n = 0;
    while (lock_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) checkOutput("ready timeout", 32'd0, 32'd1);
    lock_x     = x;
    lock_y     = y;
    lock_type  = t;
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
  endtask

  // n0 is the number of edges already elapsed since the accept edge.
  task automatic waitDone(input int expK, input string name, input int n0);
    int n = n0;
    bit seen = 1'b0;
    while (n < 40 && !seen) begin
      tick();
      n++;
      seen = (lines_done === 1'b1);
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, " done cycle"}, 32'(n), 32'(20 + expK));
      checkOutput({name, " lines_cleared"}, 32'(lines_cleared), 32'(expK));
      tick();
      checkOutput({name, " done is one pulse"}, 32'(lines_done), 32'd0);
      checkOutput({name, " ready after done"}, 32'(lock_ready), 32'd1);
    end
  endtask

  task automatic applyStimulus(input lockVec_t v, input int idx);
    int k;
    string name;
    name = $sformatf("vec%0d", idx);
    if (v.clr) applyClear();
    acceptLock(v.x, v.y, v.t);
    waitDone(v.expK, name, 0);
    modelLock(v.x, v.y, int'(v.t));
    modelScan(k);
    if (v.chk) checkBoard(name);
  endtask

  task automatic addVec(input logic [15:0] x, input logic [19:0] y, input int t,
                        input bit clr, input int expK, input bit chk);
    lockVec_t v;
    v.x = x; v.y = y; v.t = 2'(t); v.clr = clr; v.expK = expK; v.chk = chk;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    int k;

    // Single clear: row 19 cols 0-5 type 2, row 18 col 0 type 3, then complete row 19.
    addVec(px(0,1,2,3), py(19,19,19,19), 2, 1'b1, 0, 1'b0);
    addVec(px(4,5,5,5), py(19,19,19,19), 2, 1'b0, 0, 1'b0);
    addVec(px(0,0,0,0), py(18,18,18,18), 3, 1'b0, 0, 1'b0);
    addVec(px(6,7,8,9), py(19,19,19,19), 1, 1'b0, 1, 1'b1);
    // Four-line clear: rows 16-19 filled except col 9, then a vertical piece.
    for (int r = 16; r < 20; r++) begin
      addVec(px(0,1,2,3), py(r,r,r,r), 1, (r == 16), 0, 1'b0);
      addVec(px(4,5,6,7), py(r,r,r,r), 1, 1'b0, 0, 1'b0);
      addVec(px(8,8,8,8), py(r,r,r,r), 2, 1'b0, 0, 1'b0);
    end
    addVec(px(9,9,9,9), py(16,17,18,19), 3, 1'b0, 4, 1'b1);
    // Out-of-range cells are dropped, the rest still written.
    addVec(px(12,2,1,0), py(5,5,5,5), 2, 1'b1, 0, 1'b1);
    addVec(px(3,10,4,4), py(20,7,7,7), 1, 1'b0, 0, 1'b1);

    Reset_n = 1'b0; rd_col = '0; rd_row = '0; lock_valid = 1'b0;
    lock_x = '0; lock_y = '0; lock_type = '0; board_clear = 1'b0;
    modelWipe();
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();

    checkOutput("reset lock_ready", 32'(lock_ready), 32'd1);
    checkOutput("reset lines_done", 32'(lines_done), 32'd0);
    checkOutput("reset lines_cleared", 32'(lines_cleared), 32'd0);
    checkOutput("reset rd_cell", 32'(rd_cell), 32'd0);
    checkBoard("reset");

    // Simple lock, with the write-to-read latency watched at (2,19).
    rd_col = 4'd2; rd_row = 5'd19;
    acceptLock(px(0,1,2,3), py(19,19,19,19), 2'd1);
    checkOutput("read before write visible", 32'(rd_cell), 32'd0);
    tick();
    checkOutput("write visible 2 edges after accept", 32'(rd_cell), 32'd1);
    waitDone(0, "simple", 1);
    modelLock(px(0,1,2,3), py(19,19,19,19), 1);
    modelScan(k);
    readCheck(2, 19, 1, "simple (2,19)");
    readCheck(4, 19, 0, "simple (4,19)");

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // board_clear 5 cycles after an accept aborts the scan silently.
    acceptLock(px(0,1,2,3), py(19,19,19,19), 2'd1);
    repeat (4) tick();
    board_clear = 1'b1;
    tick();
    board_clear = 1'b0;
    #1;
    checkOutput("abort ready next cycle", 32'(lock_ready), 32'd1);
    modelWipe();
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (lines_done === 1'b1) seen = 1'b1;
    end
    checkOutput("abort no lines_done", 32'(seen), 32'd0);
    checkBoard("abort");

    // A lock_valid pulse during SCAN must not write anything.
    acceptLock(px(0,0,0,0), py(0,0,0,0), 2'd3);
    repeat (3) tick();
    lock_x = px(5,6,7,8); lock_y = py(3,3,3,3); lock_type = 2'd2;
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
    waitDone(0, "scan-lock", 4);
    modelLock(px(0,0,0,0), py(0,0,0,0), 3);
    modelScan(k);
    checkBoard("scan-lock");

    readCheck(15, 0, 0, "rd_col 15");
    readCheck(0, 25, 0, "rd_row 25");
    readCheck(0, 0, 3, "rd (0,0) after out-of-range");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
